// File: rtl/gray_pkg.sv
// -----------------------------------------------------------------------------
// gray_pkg
// Shared Gray-code helpers for the binary-to-Gray encoder, the pipelined
// Gray-to-binary decoder and their benches.
//   clog2        - constant ceil(log2(value))
//   chunk_size   - bits resolved per decoder stage, ceil(width/stages)
//   popcount     - number of set bits, used by the optional step check
//   binary2gray  - reference encoder
//   gray2binary  - reference decoder
// Word-level helpers operate on word_t (MAX_WIDTH bits). Narrower words are
// zero-extended, which leaves both codes unchanged.
// -----------------------------------------------------------------------------
package gray_pkg;

   localparam int MAX_WIDTH = 64;

   typedef logic [MAX_WIDTH-1:0] word_t;

   function automatic int clog2(input int value);
      int result;
      int rem;
      result = 0;
      rem    = value - 1;
      while (rem > 0) begin
         result = result + 1;
         rem    = rem >> 1;
      end
      return result;
   endfunction

   function automatic int chunk_size(input int data_width, input int stages);
      return (data_width + stages - 1) / stages;
   endfunction

   function automatic int popcount(input word_t value);
      int count;
      count = 0;
      for (int i = 0; i < MAX_WIDTH; i++) begin
         count = count + int'(value[i]);
      end
      return count;
   endfunction

   function automatic word_t binary2gray(input word_t value);
      return value ^ (value >> 1);
   endfunction

   function automatic word_t gray2binary(input word_t value);
      word_t result;
      result[MAX_WIDTH-1] = value[MAX_WIDTH-1];
      for (int i = MAX_WIDTH - 2; i >= 0; i--) begin
         result[i] = result[i+1] ^ value[i];
      end
      return result;
   endfunction

endpackage

// File: rtl/gray2bin_stage.sv
// -----------------------------------------------------------------------------
// gray2bin_stage
// One register stage of the Gray-to-binary pipeline. Bits above HI arrive
// already decoded, bits HI..LO are decoded here, bits below LO pass on as Gray.
// HI < LO (including a negative HI) makes this a plain register stage.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   data_in    - partially decoded word from the previous stage
//   valid_in   - data_in is valid
//   leave      - this stage's word is taken by the next stage / sink this cycle
//   data_out   - registered, further decoded word
//   valid_out  - data_out is valid
// -----------------------------------------------------------------------------
module gray2bin_stage
   import gray_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int HI         = 31,
   parameter int LO         = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  valid_in,
   input  logic                  leave,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  valid_out
);

   logic [DATA_WIDTH-1:0] resolved;
   logic                  load;

   // The prefix XOR is seeded by bit HI+1, which is already binary (or is the
   // MSB, which is its own binary value).
   always_comb begin
      // NOTE: full default before the loop so no bit of resolved can hold a
      // previous value, which would infer a latch.
      resolved = data_in;
      for (int i = DATA_WIDTH - 2; i >= 0; i--) begin
         if (i <= HI && i >= LO) begin
            resolved[i] = resolved[i+1] ^ data_in[i];
         end
      end
   end

   // Load whenever empty or the current word is leaving, so bubbles collapse.
   assign load = !valid_out || leave;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: sequential state uses non-blocking assignments so every stage
         // samples its neighbour's pre-edge value. The data register is reset
         // too because the last stage drives binary_out, which must read 0.
         valid_out <= 1'b0;
         data_out  <= '0;
      end else if (load) begin
         valid_out <= valid_in;
         if (valid_in) begin
            data_out <= resolved;
         end
      end
   end

endmodule

// File: rtl/gray2bin_pipe.sv
// -----------------------------------------------------------------------------
// gray2bin_pipe
// Pipelined Gray-to-binary decoder with valid/ready on both sides. The prefix
// XOR is split across STAGES register stages of ceil(DATA_WIDTH/STAGES) bits.
// Latency STAGES cycles, throughput one word per cycle.
// Parameters: DATA_WIDTH (2..64), STAGES (1..DATA_WIDTH).
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   gray_in       - Gray-coded input word
//   gray_valid    - gray_in valid
//   gray_ready    - pipeline accepts this cycle (combinational from binary_ready)
//   binary_out    - decoded word (registered)
//   binary_valid  - binary_out valid
//   binary_ready  - sink accepts binary_out
// Optional build macro GRAY2BIN_STEP_CHECK_EN adds:
//   err_clr       - clears step_err
//   step_err      - sticky flag: two consecutive accepted words differ in more
//                   than one bit (first word after reset is not checked)
// -----------------------------------------------------------------------------
module gray2bin_pipe
   import gray_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int STAGES     = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] gray_in,
   input  logic                  gray_valid,
   output logic                  gray_ready,
   output logic [DATA_WIDTH-1:0] binary_out,
   output logic                  binary_valid,
   input  logic                  binary_ready
`ifdef GRAY2BIN_STEP_CHECK_EN
   ,
   input  logic                  err_clr,
   output logic                  step_err
`endif
);

   localparam int CHUNK = chunk_size(DATA_WIDTH, STAGES);

   // Element/bit k is the input of stage k; element/bit STAGES is the output.
   logic [DATA_WIDTH-1:0] stage_data [0:STAGES];
   logic [STAGES:0]       valid_chain;
   logic [STAGES-1:0]     stage_leave;
   logic                  take;

   assign stage_data[0]  = gray_in;
   assign valid_chain[0] = gray_valid;

   // Ready ripples back from the sink: a stage's word leaves when the next
   // stage is empty or is itself emptying.
   always_comb begin
      take        = binary_ready;
      stage_leave = '0;
      for (int k = STAGES - 1; k >= 0; k--) begin
         stage_leave[k] = take;
         take           = !valid_chain[k+1] || take;
      end
   end

   assign gray_ready = take;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int HI     = DATA_WIDTH - 1 - k * CHUNK;
      localparam int LO_RAW = DATA_WIDTH - (k + 1) * CHUNK;
      localparam int LO     = (LO_RAW > 0) ? LO_RAW : 0;

      gray2bin_stage #(
         .DATA_WIDTH (DATA_WIDTH),
         .HI         (HI),
         .LO         (LO)
      ) u_stage (
         .clk       (clk),
         .rst       (rst),
         .data_in   (stage_data[k]),
         .valid_in  (valid_chain[k]),
         .leave     (stage_leave[k]),
         .data_out  (stage_data[k+1]),
         .valid_out (valid_chain[k+1])
      );
   end

   assign binary_out   = stage_data[STAGES];
   assign binary_valid = valid_chain[STAGES];

`ifdef GRAY2BIN_STEP_CHECK_EN
   logic [DATA_WIDTH-1:0] prev_gray;
   logic                  have_prev;
   logic                  step_set;
   word_t                 step_diff;

   // Watches accepted inputs only; the decode path is untouched.
   always_comb begin
      step_diff                 = '0;
      step_diff[DATA_WIDTH-1:0] = gray_in ^ prev_gray;
      step_set = gray_valid && gray_ready && have_prev && (popcount(step_diff) > 1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_gray <= '0;
         have_prev <= 1'b0;
         step_err  <= 1'b0;
      end else begin
         if (gray_valid && gray_ready) begin
            prev_gray <= gray_in;
            have_prev <= 1'b1;
         end
         // A new violation wins over a simultaneous clear.
         if (step_set) begin
            step_err <= 1'b1;
         end else if (err_clr) begin
            step_err <= 1'b0;
         end
      end
   end
`endif

endmodule

// File: tb/tb_gray2bin_pipe.sv
// -----------------------------------------------------------------------------
// tb_gray2bin_pipe
// Self-checking bench for gray2bin_pipe (DATA_WIDTH=32, STAGES=4). Expected
// words come from a parity model (binary bit i = XOR of Gray bits i and up)
// held in a scoreboard queue; one monitor compares every delivered word,
// hold-while-stalled and the gray_ready rule on every cycle.
// Build with GRAY2BIN_STEP_CHECK_EN to include the step-check tests.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_gray2bin_pipe;
   import gray_pkg::*;

   localparam int DW = 32;
   localparam int ST = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [DW-1:0] gray_in = '0;
   logic          gray_valid = 1'b0;
   logic          gray_ready;
   logic [DW-1:0] binary_out;
   logic          binary_valid;
   logic          binary_ready = 1'b1;
`ifdef GRAY2BIN_STEP_CHECK_EN
   logic          err_clr = 1'b0;
   logic          step_err;
`endif

   always #5 clk = ~clk;

   gray2bin_pipe #(
      .DATA_WIDTH (DW),
      .STAGES     (ST)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .gray_in      (gray_in),
      .gray_valid   (gray_valid),
      .gray_ready   (gray_ready),
      .binary_out   (binary_out),
      .binary_valid (binary_valid),
      .binary_ready (binary_ready)
`ifdef GRAY2BIN_STEP_CHECK_EN
      ,
      .err_clr      (err_clr),
      .step_err     (step_err)
`endif
   );

   int            n_checks = 0;
   int            n_fail   = 0;
   logic [DW-1:0] exp_q [$];
   int            cycle = 0;
   int            deliv_count = 0;
   int            last_deliv_cyc = 0;
   int            last_acc_cyc = 0;
   int            ready_low_count = 0;
   bit            stall_prev = 1'b0;
   logic [DW-1:0] stall_data = '0;
   bit            bp_en = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s (t=%0t)", name, $time);
   endtask

   // Binary bit i is the parity of all Gray bits at or above i.
   function automatic logic [DW-1:0] model_g2b(input logic [DW-1:0] g);
      logic [DW-1:0] b;
      for (int i = 0; i < DW; i++) b[i] = ^(g >> i);
      return b;
   endfunction

   // Monitor: sample in the middle of the cycle, well away from the rising edge.
   initial begin
      forever begin
         @(negedge clk);
         cycle++;
         if (rst) begin
            stall_prev = 1'b0;
         end else begin
            if (stall_prev) begin
               check("hold_valid", binary_valid, 1'b1);
               check("hold_data", binary_out, stall_data);
            end
            check("gray_ready_rule", gray_ready, !(exp_q.size() == ST && !binary_ready));
            if (gray_valid && !gray_ready) ready_low_count++;
            if (binary_valid && binary_ready) begin
               if (exp_q.size() == 0) fail_now("unexpected_output");
               else check("binary_out", binary_out, exp_q.pop_front());
               deliv_count++;
               last_deliv_cyc = cycle;
            end
            stall_prev = binary_valid && !binary_ready;
            stall_data = binary_out;
            if (gray_valid && gray_ready) begin
               exp_q.push_back(model_g2b(gray_in));
               last_acc_cyc = cycle;
            end
         end
      end
   end

   // Random sink backpressure.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (bp_en) binary_ready = ($urandom_range(0, 1) == 1);
      end
   end

   // Present one word and return 1 ns after the edge that accepts it.
   task automatic send(input logic [DW-1:0] w);
      int guard;
      guard      = 0;
      gray_in    = w;
      gray_valid = 1'b1;
      @(negedge clk);
      while (!gray_ready && guard < 1000) begin
         @(negedge clk);
         guard++;
      end
      if (!gray_ready) fail_now("send_timeout");
      @(posedge clk);
      #1;
   endtask

   task automatic wait_drain(input string name);
      int guard;
      guard = 0;
      while (exp_q.size() != 0 && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
      if (exp_q.size() != 0) fail_now(name);
      @(posedge clk);
      #1;
   endtask

   task automatic run_single(input string name, input logic [DW-1:0] g, input logic [DW-1:0] expect_b);
      int lat;
      binary_ready = 1'b1;
      send(g);
      gray_valid = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!binary_valid && lat < 20);
      check({name, "_latency"}, lat, ST);
      check(name, binary_out, expect_b);
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      int base_deliv;
      int base_low;
      int t0;
      word_t tmp;

      #5_000_000;
      $display("FAIL watchdog_expired (t=%0t)", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int base_deliv;
      int base_low;
      int t0;
      int n_acc;
      word_t tmp;

      // Model pins.
      check("model_7", model_g2b(32'h0000_0007), 32'h0000_0005);
      check("model_8000", model_g2b(32'h8000_0000), 32'hFFFF_FFFF);
      check("model_c000", model_g2b(32'hC000_0000), 32'h8000_0000);

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      check("rst_binary_valid", binary_valid, 1'b0);
      check("rst_binary_out", binary_out, '0);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_gray_ready", gray_ready, 1'b1);
      @(posedge clk);
      #1;

      // Single words and MSB boundaries.
      run_single("single_7", 32'h0000_0007, 32'h0000_0005);
      run_single("msb_only", 32'h8000_0000, 32'hFFFF_FFFF);
      run_single("lsb_only", 32'h0000_0001, 32'h0000_0001);
      run_single("top_two", 32'hC000_0000, 32'h8000_0000);
      run_single("chunk_edge", 32'h0100_0000, 32'h01FF_FFFF);

      // Back-to-back stream of an incrementing counter.
      binary_ready = 1'b1;
      base_deliv   = deliv_count;
      base_low     = ready_low_count;
      for (int i = 0; i < 1024; i++) begin
         tmp = binary2gray(word_t'(i));
         send(tmp[DW-1:0]);
         if (i == 0) t0 = last_acc_cyc;
      end
      gray_valid = 1'b0;
      wait_drain("stream_drain_timeout");
      check("stream_count", deliv_count - base_deliv, 1024);
      check("stream_accept_span", last_acc_cyc - t0, 1023);
      check("stream_last_latency", last_deliv_cyc - last_acc_cyc, ST);
      check("stream_ready_low", ready_low_count - base_low, 0);

      // Random data, random input gaps, random backpressure.
      base_deliv = deliv_count;
      n_acc      = 0;
      bp_en      = 1'b1;
      while (n_acc < 2000) begin
         if ($urandom_range(0, 3) == 0) begin
            gray_valid = 1'b0;
            gray_in    = DW'($urandom);
            @(posedge clk);
            #1;
         end else begin
            send(DW'($urandom));
            n_acc++;
         end
      end
      gray_valid = 1'b0;
      bp_en      = 1'b0;
      @(posedge clk);
      #1;
      binary_ready = 1'b1;
      wait_drain("random_drain_timeout");
      check("random_count", deliv_count - base_deliv, 2000);

      // Reset with three words in flight.
      binary_ready = 1'b0;
      send(32'h1234_5678);
      send(32'h0000_00FF);
      send(32'hFFFF_0000);
      gray_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("pre_rst_valid", binary_valid, 1'b1);
      #1;
      rst = 1'b1;
      #1;
      check("mid_rst_binary_valid", binary_valid, 1'b0);
      check("mid_rst_binary_out", binary_out, '0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst          = 1'b0;
      binary_ready = 1'b1;
      @(negedge clk);
      check("mid_rst_gray_ready", gray_ready, 1'b1);
      check("mid_rst_no_stale", binary_valid, 1'b0);
      @(posedge clk);
      #1;
      run_single("after_rst_3", 32'h0000_0003, 32'h0000_0002);

`ifdef GRAY2BIN_STEP_CHECK_EN
      // Legal single-bit steps.
      pulse_reset();
      send(32'h0);
      send(32'h1);
      send(32'h3);
      send(32'h3);
      gray_valid = 1'b0;
      check("step_legal", step_err, 1'b0);
      // Two-bit jump sets the sticky flag.
      pulse_reset();
      send(32'h0);
      send(32'h3);
      gray_valid = 1'b0;
      check("step_jump", step_err, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      check("step_sticky", step_err, 1'b1);
      send(32'h2);
      gray_valid = 1'b0;
      check("step_sticky_legal", step_err, 1'b1);
      err_clr = 1'b1;
      @(posedge clk);
      #1;
      err_clr = 1'b0;
      check("step_cleared", step_err, 1'b0);
      err_clr = 1'b1;
      send(32'h1);
      err_clr    = 1'b0;
      gray_valid = 1'b0;
      check("step_set_wins", step_err, 1'b1);
      wait_drain("step_drain_timeout");
`endif

      check("final_queue_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
